// File: rtl/rv_instr_encoder_if.sv
// Request, output-word and error-report signals of the RV32I/RV64I instruction encoder.
// The encoder takes the slave side; the producer/consumer/monitor takes the master side.
interface rv_instr_encoder_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_type;
  logic [2:0]           in_funct3;
  logic [6:0]           in_funct7;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [31:0]          in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 err_valid;
  logic [1:0]           err_code;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_type, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, err_valid, err_code, err_count
  );

  modport master (
    output in_valid, in_type, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, err_valid, err_code, err_count
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Field-level request to 32-bit RV32I/RV64I instruction word: one registered encode stage
// followed by an output FIFO; illegal requests are dropped and reported.
module rv_instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  rv_instr_encoder_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [4:0] TypeLoad    = 5'b00000;
  localparam logic [4:0] TypeStore   = 5'b01000;
  localparam logic [4:0] TypeBranch  = 5'b11000;
  localparam logic [4:0] TypeJalr    = 5'b11001;
  localparam logic [4:0] TypeJal     = 5'b11011;
  localparam logic [4:0] TypeOpImm   = 5'b00100;
  localparam logic [4:0] TypeOp      = 5'b01100;
  localparam logic [4:0] TypeLui     = 5'b01101;
  localparam logic [4:0] TypeAuipc   = 5'b00101;
  localparam logic [4:0] TypeOpImm32 = 5'b00110;
  localparam logic [4:0] TypeOp32    = 5'b01110;

  localparam logic [1:0] ErrNone  = 2'b00;
  localparam logic [1:0] ErrType  = 2'b01;
  localparam logic [1:0] ErrRange = 2'b10;
  localparam logic [1:0] ErrAlign = 2'b11;

  // True when v is the sign extension of its bit msb.
  function automatic logic fits_sext(input logic [31:0] v, input int unsigned msb);
    logic signed [31:0] hi;
    hi = $signed(v) >>> msb;
    return (hi == '0) || (hi == '1);
  endfunction

  logic              accept;
  logic [31:0]       enc_instr;
  logic [1:0]        enc_err;
  logic [6:0]        opcode;
  logic [31:0]       imm;

  logic              s1_valid_q;
  logic [31:0]       s1_instr_q;
  logic [1:0]        s1_err_q;

  logic [31:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic [PtrW+1:0]   occupancy;
  logic              push, pop, out_valid;

  logic              err_valid_q;
  logic [1:0]        err_code_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  assign opcode = {bus.in_type, 2'b11};
  assign imm    = bus.in_imm;

  always_comb begin
    enc_instr = '0;
    enc_err   = ErrNone;
    case (bus.in_type)
      TypeOp, TypeOp32: begin
        enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
      end
      TypeLoad, TypeJalr, TypeOpImm, TypeOpImm32: begin
        enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
        // Shift-immediates carry shamt plus funct bits in imm[11:0]; no sign check.
        if (!(((bus.in_type == TypeOpImm) || (bus.in_type == TypeOpImm32)) &&
              (bus.in_funct3[1:0] == 2'b01)) && !fits_sext(imm, 11)) begin
          enc_err = ErrRange;
        end
      end
      TypeStore: begin
        enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], opcode};
        if (!fits_sext(imm, 11)) enc_err = ErrRange;
      end
      TypeBranch: begin
        enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     imm[4:1], imm[11], opcode};
        if (imm[0])                  enc_err = ErrAlign;
        else if (!fits_sext(imm, 12)) enc_err = ErrRange;
      end
      TypeLui, TypeAuipc: begin
        enc_instr = {imm[31:12], bus.in_rd, opcode};
      end
      TypeJal: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, opcode};
        if (imm[0])                  enc_err = ErrAlign;
        else if (!fits_sext(imm, 20)) enc_err = ErrRange;
      end
      default: enc_err = ErrType;
    endcase
  end

  // Occupancy counts the in-flight stage-1 word, so a FIFO slot is reserved at acceptance.
  assign occupancy    = {1'b0, count_q} + {{(PtrW + 1){1'b0}}, s1_valid_q};
  assign bus.in_ready = occupancy < (PtrW + 2)'(DEPTH);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_err_q   <= ErrNone;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_instr_q <= enc_instr;
        s1_err_q   <= enc_err;
      end
    end
  end

  assign out_valid = (count_q != '0);
  assign push      = s1_valid_q && (s1_err_q == ErrNone);
  assign pop       = out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s1_instr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ErrNone;
      err_count_q <= '0;
    end else begin
      err_valid_q <= s1_valid_q && (s1_err_q != ErrNone);
      if (s1_valid_q && (s1_err_q != ErrNone)) begin
        err_code_q <= s1_err_q;
        if (err_count_q != '1) err_count_q <= err_count_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_count = err_count_q;
endmodule
